// File: rtl/lcd_cmd_sequencer.sv
// HD44780 command/data sequencer behind an Avalon-MM slave.
// Runs a fixed init ROM after power-up, then drains a 4-entry write FIFO.
module lcd_cmd_sequencer #(
    parameter int unsigned T_PWRUP     = 750000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EN        = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
);

    localparam int unsigned L_PWRUP = (T_PWRUP == 0) ? 1 : T_PWRUP;
    localparam int unsigned L_SETUP = (T_SETUP == 0) ? 1 : T_SETUP;
    localparam int unsigned L_EN    = (T_EN == 0) ? 1 : T_EN;
    localparam int unsigned L_HOLD  = (T_HOLD == 0) ? 1 : T_HOLD;
    localparam int unsigned L_EXEC  = (T_EXEC == 0) ? 1 : T_EXEC;
    localparam int unsigned L_LONG  = (T_EXEC_LONG == 0) ? 1 : T_EXEC_LONG;
    localparam int unsigned M1 = (L_PWRUP > L_LONG) ? L_PWRUP : L_LONG;
    localparam int unsigned M2 = (L_EXEC > L_EN) ? L_EXEC : L_EN;
    localparam int unsigned M3 = (L_SETUP > L_HOLD) ? L_SETUP : L_HOLD;
    localparam int unsigned M4 = (M1 > M2) ? M1 : M2;
    localparam int unsigned MAXV = (M4 > M3) ? M4 : M3;
    localparam int CW = $clog2(MAXV + 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_EXEC
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, lim_m1;
    logic [1:0]      rom_idx_q, rom_idx_d;
    logic            init_done_q, init_done_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [8:0]      fifo_q [4];
    logic [1:0]      wr_ptr_q, rd_ptr_q;
    logic [2:0]      level_q;
    logic            ovf_q;
    logic            wr_en, push_req, push, pop, full, empty, busy;
    logic            long_cmd, done, wd_unused;

    function automatic logic [7:0] rom(input logic [1:0] i);
        case (i)
            2'd0:    rom = 8'h38;
            2'd1:    rom = 8'h0C;
            2'd2:    rom = 8'h01;
            default: rom = 8'h06;
        endcase
    endfunction

    assign wd_unused = ^writedata[31:9];
    assign wr_en     = chipselect & ~write_n;
    assign push_req  = wr_en & (address == 2'd0);
    assign full      = (level_q == 3'd4);
    assign empty     = (level_q == 3'd0);
    assign pop       = (state_q == S_IDLE) & init_done_q & ~empty;
    assign push      = push_req & (~full | pop);
    assign busy      = (state_q != S_IDLE) | ~empty;
    // Clear/home (0x01-0x03) need the long execution wait
    assign long_cmd  = ~rs_q & (data_q[7:2] == 6'd0) & (data_q != 8'd0);

    always_comb begin
        lim_m1 = '0;
        unique case (state_q)
            S_PWRUP:  lim_m1 = CW'(L_PWRUP - 1);
            S_SETUP:  lim_m1 = CW'(L_SETUP - 1);
            S_ENABLE: lim_m1 = CW'(L_EN - 1);
            S_HOLD:   lim_m1 = CW'(L_HOLD - 1);
            S_EXEC:   lim_m1 = long_cmd ? CW'(L_LONG - 1) : CW'(L_EXEC - 1);
            default:  lim_m1 = '0;
        endcase
    end

    assign done = (cnt_q == lim_m1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_idx_d   = rom_idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        data_d      = data_q;
        if (state_q != S_IDLE) begin
            cnt_d = done ? '0 : cnt_q + CW'(1);
        end
        unique case (state_q)
            S_PWRUP: if (done) begin
                state_d   = S_SETUP;
                rom_idx_d = 2'd0;
                rs_d      = 1'b0;
                data_d    = rom(2'd0);
            end
            S_IDLE: if (pop) begin
                state_d = S_SETUP;
                rs_d    = fifo_q[rd_ptr_q][8];
                data_d  = fifo_q[rd_ptr_q][7:0];
            end
            S_SETUP:  if (done) state_d = S_ENABLE;
            S_ENABLE: if (done) state_d = S_HOLD;
            S_HOLD:   if (done) state_d = S_EXEC;
            S_EXEC: if (done) begin
                if (init_done_q) begin
                    state_d = S_IDLE;
                end else if (rom_idx_q == 2'd3) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rom_idx_d = rom_idx_q + 2'd1;
                    rs_d      = 1'b0;
                    data_d    = rom(rom_idx_q + 2'd1);
                    state_d   = S_SETUP;
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            rom_idx_q   <= 2'd0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'd0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            level_q     <= 3'd0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_idx_q   <= rom_idx_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= writedata[8:0];
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            if (push && !pop) level_q <= level_q + 3'd1;
            else if (!push && pop) level_q <= level_q - 3'd1;
            if (push_req && full && !pop) ovf_q <= 1'b1;
            else if (wr_en && address == 2'd1 && writedata[3]) ovf_q <= 1'b0;
        end
    end

    assign readdata = (address == 2'd1) ?
        {21'd0, level_q, 3'd0, init_done_q, ovf_q, empty, full, busy} : 32'd0;
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = (state_q == S_ENABLE);

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: frame monitor on the LCD bus plus
// a timing model built from state durations.
module tb_lcd_cmd_sequencer;

    localparam int TP = 10, TS = 1, TE = 3, TH = 1, TX = 5, TL = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en;

    lcd_cmd_sequencer #(
        .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
        .T_EXEC(TX), .T_EXEC_LONG(TL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         en_len;
        int         rise;
        logic       stable;
    } frame_t;

    frame_t     got[$];
    frame_t     cur;
    logic       prev_en = 1'b0, prev_rs = 1'b0;
    logic [7:0] prev_data = 8'd0;

    // Captures each lcd_en pulse and whether RS/data held around it
    always @(negedge clk) begin
        if (lcd_en && !prev_en) begin
            cur.rs = lcd_rs;
            cur.data = lcd_data;
            cur.en_len = 1;
            cur.rise = cyc;
            cur.stable = (prev_rs === lcd_rs) && (prev_data === lcd_data);
        end else if (lcd_en) begin
            cur.en_len = cur.en_len + 1;
            if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
        end else if (prev_en) begin
            if (lcd_rs !== cur.rs || lcd_data !== cur.data) cur.stable = 1'b0;
            got.push_back(cur);
        end
        prev_en = lcd_en;
        prev_rs = lcd_rs;
        prev_data = lcd_data;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] rom_exp [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exec_of(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? TL : TX;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b0;
        writedata = d;
        step();
        chipselect = 1'b0;
        write_n = 1'b1;
        writedata = 32'd0;
        address = 2'd1;
        #1;
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while (readdata[0] && n < lim) begin
            step();
            n++;
        end
        chk("idle_reached", {31'd0, readdata[0]}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic rs,
                               input logic [7:0] d);
        frame_t f;
        chk({tag, "_present"}, (got.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (got.size() > 0) begin
            f = got.pop_front();
            chk({tag, "_rs"}, {31'd0, f.rs}, {31'd0, rs});
            chk({tag, "_data"}, {24'd0, f.data}, {24'd0, d});
            chk({tag, "_enlen"}, f.en_len, TE);
            chk({tag, "_stable"}, {31'd0, f.stable}, 32'd1);
        end
    endtask

    task automatic check_init(input int r);
        int n;
        int acc;
        n = 0;
        while (!readdata[4] && n < 400) begin
            step();
            n++;
        end
        acc = 0;
        for (int i = 0; i < 4; i++) acc += TS + TE + TH + exec_of(1'b0, rom_exp[i]);
        chk("init_done_cyc", cyc, r + TP + acc);
        chk("init_frames", got.size(), 4);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            if (got.size() > 0) begin
                chk($sformatf("init%0d_rise", i), got[0].rise, r + TP + TS + acc);
                check_frame($sformatf("init%0d", i), 1'b0, rom_exp[i]);
            end
            acc += TS + TE + TH + exec_of(1'b0, rom_exp[i]);
        end
    endtask

    task automatic single(input string tag, input logic rs, input logic [7:0] d);
        int n;
        wr(2'd0, {23'd0, rs, d});
        wait_idle(200, n);
        chk({tag, "_busy"}, n, 1 + TS + TE + TH + exec_of(rs, d));
        chk({tag, "_cnt"}, got.size(), 1);
        check_frame(tag, rs, d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n, t_idle;
        logic rs;
        logic [7:0] d;
        logic [8:0] exp_q[$];
        frame_t f1, f2;

        step();
        step();
        chk("rst_status", readdata, 32'h5);
        chk("rst_en", {31'd0, lcd_en}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'd0);
        chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
        reset_n = 1'b1;
        r = cyc;
        check_init(r);
        chk("idle_status", readdata, 32'h14);

        for (int a = 0; a < 4; a++) begin
            if (a != 1) begin
                address = 2'(a);
                #1;
                chk($sformatf("rd_addr%0d", a), readdata, 32'd0);
                address = 2'd1;
                #1;
            end
        end

        single("w141", 1'b1, 8'h41);

        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                rs = 1'b0;
                d = 8'($urandom_range(1, 3));
            end
            single($sformatf("rnd%0d", i), rs, d);
        end

        wr(2'd0, 32'h001);
        wr(2'd0, 32'h004);
        wait_idle(200, n);
        t_idle = cyc;
        chk("long_cnt", got.size(), 2);
        if (got.size() == 2) begin
            f1 = got.pop_front();
            f2 = got.pop_front();
            chk("long_d1", {24'd0, f1.data}, 32'h01);
            chk("long_d2", {24'd0, f2.data}, 32'h04);
            chk("long_gap", f2.rise - f1.rise, TE + TH + TL + 1 + TS);
            chk("short_tail", t_idle - f2.rise, TE + TH + TX);
        end

        exp_q.delete();
        wr(2'd0, 32'h141);
        step();
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            wr(2'd0, {24'h000001, d});
            if (i < 4) exp_q.push_back({1'b1, d});
        end
        chk("ovf_level", {29'd0, readdata[10:8]}, 32'd4);
        chk("ovf_full", {31'd0, readdata[1]}, 32'd1);
        chk("ovf_set", {31'd0, readdata[3]}, 32'd1);
        wr(2'd1, 32'hFFFF_FFF7);
        wr(2'd2, 32'h8);
        wr(2'd3, 32'h8);
        chk("ovf_kept", {31'd0, readdata[3]}, 32'd1);
        chk("ovf_level2", {29'd0, readdata[10:8]}, 32'd4);
        wr(2'd1, 32'h8);
        chk("ovf_clr", {31'd0, readdata[3]}, 32'd0);
        wait_idle(400, n);
        chk("ovf_frames", got.size(), 5);
        check_frame("ovf_a", 1'b1, 8'h41);
        for (int i = 0; i < 4; i++)
            check_frame($sformatf("ovf%0d", i), exp_q[i][8], exp_q[i][7:0]);

        exp_q.delete();
        wr(2'd0, 32'h141);
        step();
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            wr(2'd0, {24'h000001, d});
            exp_q.push_back({1'b1, d});
        end
        for (int i = 0; i < 6; i++) step();
        d = 8'($urandom_range(0, 255));
        wr(2'd0, {24'h000001, d});
        exp_q.push_back({1'b1, d});
        chk("popw_level", {29'd0, readdata[10:8]}, 32'd4);
        chk("popw_full", {31'd0, readdata[1]}, 32'd1);
        chk("popw_ovf", {31'd0, readdata[3]}, 32'd0);
        wait_idle(400, n);
        chk("popw_frames", got.size(), 6);
        check_frame("popw_a", 1'b1, 8'h41);
        for (int i = 0; i < 5; i++)
            check_frame($sformatf("popw%0d", i), exp_q[i][8], exp_q[i][7:0]);

        wr(2'd0, 32'h141);
        wr(2'd0, 32'h142);
        n = 0;
        while (!lcd_en && n < 20) begin
            step();
            n++;
        end
        chk("mid_en_seen", {31'd0, lcd_en}, 32'd1);
        reset_n = 1'b0;
        step();
        chk("mid_en_low", {31'd0, lcd_en}, 32'd0);
        chk("mid_status", readdata, 32'h5);
        reset_n = 1'b1;
        r = cyc;
        @(negedge clk);
        #1;
        got.delete();
        check_init(r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
